// File: rtl/dsp_mac_sequencer.sv
// Sequencer for a DSP48A1-style MAC slice: drives the A/B, M and P clock
// enables, the P clear and OPMODE so that P accumulates sum(A*B) over a job.
module dsp_mac_sequencer #(
  parameter int         PIPE_LAT = 3,
  parameter int         LEN_W    = 8,
  parameter logic [7:0] OP_FIRST = 8'h01,
  parameter logic [7:0] OP_ACC   = 8'h09
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_in,
  output logic             ce_m,
  output logic             ce_p,
  output logic             rst_p,
  output logic [7:0]       opmode,
  output logic             result_valid
);

  localparam int D = PIPE_LAT - 1;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [D-1:0]     vld_q;
  logic [D-1:0]     fst_q;
  logic             busy_q;
  logic             rv_q;

  logic hs;
  logic last_hs;
  logic tail_empty;

  assign in_ready = ~rst & (state_q == FEED) & (cnt_q < len_q);
  assign hs       = in_valid & in_ready;
  assign ce_in    = hs;
  assign last_hs  = hs & (cnt_q == len_q - ONE);

  // Tags ride a shift register so each CE lines up with its slice stage.
  assign ce_m       = ~rst & vld_q[PIPE_LAT-3];
  assign ce_p       = ~rst & vld_q[PIPE_LAT-2];
  assign opmode     = fst_q[PIPE_LAT-2] ? OP_FIRST : OP_ACC;
  assign tail_empty = ~|vld_q[D-2:0];

  assign rst_p        = rst | (state_q == CLEAR);
  assign busy         = busy_q;
  assign result_valid = rv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      fst_q   <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      vld_q <= {vld_q[D-2:0], hs};
      fst_q <= {fst_q[D-2:0], hs & (cnt_q == '0)};
      rv_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          if (len_q == '0) begin
            rv_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= FEED;
          end
        end
        FEED: begin
          if (hs) begin
            cnt_q <= cnt_q + ONE;
            if (last_hs) state_q <= DRAIN;
          end
        end
        // Leave once only the final tag, now at the P stage, remains.
        DRAIN: begin
          if (tail_empty) begin
            rv_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Control sequencer for one DSP48A1-style multiply-accumulate slice built from the team's pipeline register/mux stages (A/B input regs → M reg → P reg). It accepts a job of `len` operand pairs over a valid/ready stream and drives the slice clock enables and P reset. It also drives OPMODE, timed per pipeline stage so that P = Σ A·B over the job. It signals completion when P holds the final sum.

Parameters:
- PIPE_LAT, 3, register stages from operand ports to P inclusive (A/B, M, P); legal range 3..8; extra stages are treated as additional input stages ahead of M.
- LEN_W, 8, width of the job-length field.
- OP_FIRST, 8'h01, OPMODE for the first product of a job (X=M, Z=0 → P = M).
- OP_ACC, 8'h09, OPMODE for subsequent products (X=M, Z=P → P = P + M).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin job; sampled only in IDLE
- len  in  LEN_W  number of operand pairs; captured with start
- busy  out  1  high from the cycle after start acceptance through the DONE cycle
- in_valid  in  1  operand pair on slice A/B ports is valid
- in_ready  out  1  sequencer accepts the pair this cycle
- ce_in  out  1  CE for A/B input register stage(s)
- ce_m  out  1  CE for M register
- ce_p  out  1  CE for P register
- rst_p  out  1  synchronous clear of P register
- opmode  out  8  slice OPMODE
- result_valid  out  1  one-cycle pulse: P holds the job result

Behaviour:
- Reset state: state=IDLE, len/count regs=0, tag shift registers cleared. Outputs: busy=0, in_ready=0, ce_in=ce_m=ce_p=0, opmode=OP_ACC, result_valid=0.
- rst_p=1 for every cycle rst is high.
- Reset mid-job aborts immediately; there is no partial result_valid.
- States: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: start=1 captures len and moves to CLEAR. start is ignored in all other states.
- CLEAR: exactly 1 cycle with rst_p=1. Next state is FEED, or DONE if len==0 (result 0).
- FEED:
  - in_ready = 1 while accepted count < len.
  - Handshake = in_valid & in_ready.
  - ce_in = handshake, combinational, same cycle.
  - Each handshake pushes tag {vld=1, first=(count==0)} into a (PIPE_LAT-1)-deep shift register. The register shifts every cycle; a zero tag is pushed on non-handshake cycles.
  - The handshake on the len-th pair moves to DRAIN.
  - in_valid gaps are allowed; throughput is 1 pair/cycle.
- Stage alignment:
  - ce_m = vld at shift index PIPE_LAT-3.
  - ce_p = vld at index PIPE_LAT-2.
  - opmode = OP_FIRST when the index PIPE_LAT-2 tag has first=1, else OP_ACC.
  - Net effect: a pair accepted in cycle t gets ce_m in cycle t+PIPE_LAT-2 and ce_p in cycle t+PIPE_LAT-1.
- DRAIN: in_ready=0. Exit to DONE at the edge where no vld remains below the top index, i.e. the last ce_p is asserted this cycle.
- DONE: 1 cycle, result_valid=1, busy=1, all CEs 0, then IDLE.
- Latency: result_valid occurs exactly PIPE_LAT cycles after the last handshake cycle. For len==0, DONE immediately follows CLEAR.
- start held high in DONE does not retrigger; a new start is taken in IDLE on the following cycle at earliest.
- Counter width is LEN_W. len = 2^LEN_W−1 must complete without wrap.

Test Plan:
- PIPE_LAT=3, start with len=1 at cycle 0, A=3,B=4 valid at cycle 2 → rst_p cycle 1, ce_in cycle 2, ce_m cycle 3, ce_p cycle 4 with opmode=0x01, result_valid cycle 5, P=12.
- len=4, back-to-back pairs (1,1),(2,2),(3,3),(4,4) → opmode 0x01 then 0x09 ×3 on consecutive ce_p cycles, P=30, result_valid 3 cycles after 4th handshake.
- len=3 with in_valid dropped for 2 cycles between pairs → ce_m/ce_p gaps mirror input gaps, final P=Σ products, exactly 3 ce_p pulses.
- len=0 → rst_p 1 cycle, result_valid next cycle, no CE pulses, P=0.
- rst asserted during FEED after 2 of 5 pairs → next cycle state IDLE, busy=0, all CEs 0, rst_p=1 while rst high, no result_valid.
- start pulsed while busy and held through DONE → ignored; second job starts only from IDLE, result of first job unaffected.
